// File: rtl/router_ctrl_fsm.sv
// Control FSM for the 1x3 packet router. It decodes the header address, waits for
// the target FIFO to drain, and sequences the header, payload, parity and full-stall loads.
module router_ctrl_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_packet_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       ld_state,
  output logic       laf_state,
  output logic       lfd_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy
);

  localparam logic [3:0] DECODE_ADDRESS     = 4'b0001;
  localparam logic [3:0] WAIT_TILL_EMPTY    = 4'b0010;
  localparam logic [3:0] LOAD_FIRST_DATA    = 4'b0011;
  localparam logic [3:0] LOAD_DATA          = 4'b0100;
  localparam logic [3:0] LOAD_PARITY        = 4'b0101;
  localparam logic [3:0] FIFO_FULL_STATE    = 4'b0110;
  localparam logic [3:0] LOAD_AFTER_FULL    = 4'b0111;
  localparam logic [3:0] CHECK_PARITY_ERROR = 4'b1000;

  logic [3:0] present_state;
  logic [3:0] next_state;
  logic [1:0] addr_q;
  logic [1:0] addr_d;
  logic       empty_hdr;
  logic       empty_lat;
  logic       soft_rst_lat;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of block ordering.
  always_ff @(posedge clock) begin
    if (resetn) begin
      present_state <= DECODE_ADDRESS;
      addr_q        <= 2'b00;
    end else begin
      present_state <= next_state;
      addr_q        <= addr_d;
    end
  end

  // Address is only captured while a header is being presented.
  always_comb begin
    addr_d = addr_q;
    if (present_state == DECODE_ADDRESS && pkt_valid) begin
      addr_d = data_in;
    end
  end

  always_comb begin
    empty_hdr = 1'b0;
    case (data_in)
      2'b00:   empty_hdr = fifo_empty_0;
      2'b01:   empty_hdr = fifo_empty_1;
      2'b10:   empty_hdr = fifo_empty_2;
      default: empty_hdr = 1'b0;
    endcase
  end

  always_comb begin
    empty_lat    = 1'b0;
    soft_rst_lat = 1'b0;
    case (addr_q)
      2'b00: begin
        empty_lat    = fifo_empty_0;
        soft_rst_lat = soft_reset_0;
      end
      2'b01: begin
        empty_lat    = fifo_empty_1;
        soft_rst_lat = soft_reset_1;
      end
      2'b10: begin
        empty_lat    = fifo_empty_2;
        soft_rst_lat = soft_reset_2;
      end
      default: begin
        empty_lat    = 1'b0;
        soft_rst_lat = 1'b0;
      end
    endcase
  end

  // NOTE: next_state gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state = DECODE_ADDRESS;
    if (present_state != DECODE_ADDRESS && soft_rst_lat) begin
      next_state = DECODE_ADDRESS;
    end else begin
      case (present_state)
        DECODE_ADDRESS: begin
          // An unknown or low pkt_valid, or address 2'b11, keeps the FSM idle.
          next_state = DECODE_ADDRESS;
          if (pkt_valid && data_in != 2'b11) begin
            if (empty_hdr) next_state = LOAD_FIRST_DATA;
            else           next_state = WAIT_TILL_EMPTY;
          end
        end
        WAIT_TILL_EMPTY: begin
          if (empty_lat) next_state = LOAD_FIRST_DATA;
          else           next_state = WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: next_state = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       next_state = FIFO_FULL_STATE;
          else if (!pkt_valid) next_state = LOAD_PARITY;
          else                 next_state = LOAD_DATA;
        end
        FIFO_FULL_STATE: begin
          if (fifo_full) next_state = FIFO_FULL_STATE;
          else           next_state = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)           next_state = DECODE_ADDRESS;
          else if (low_packet_valid) next_state = LOAD_PARITY;
          else                       next_state = LOAD_DATA;
        end
        LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (fifo_full) next_state = FIFO_FULL_STATE;
          else           next_state = DECODE_ADDRESS;
        end
        default: next_state = DECODE_ADDRESS;
      endcase
    end
  end

  assign detect_add    = (present_state == DECODE_ADDRESS);
  assign lfd_state     = (present_state == LOAD_FIRST_DATA);
  assign ld_state      = (present_state == LOAD_DATA);
  assign laf_state     = (present_state == LOAD_AFTER_FULL);
  assign full_state    = (present_state == FIFO_FULL_STATE);
  assign rst_int_reg   = (present_state == CHECK_PARITY_ERROR);
  assign write_enb_reg = (present_state == LOAD_DATA) || (present_state == LOAD_PARITY) ||
                         (present_state == LOAD_AFTER_FULL);
  assign busy          = !((present_state == DECODE_ADDRESS) || (present_state == LOAD_DATA));

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Scoreboard bench for router_ctrl_fsm: directed input vectors push the expected
// next state into a queue; a monitor compares state and strobes after each edge.
module tb_router_ctrl_fsm;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_packet_valid;
  logic       write_enb_reg, detect_add, ld_state, laf_state;
  logic       lfd_state, full_state, rst_int_reg, busy;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  always #5 clock = ~clock;

  router_ctrl_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .write_enb_reg(write_enb_reg),
    .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
    .lfd_state(lfd_state), .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy)
  );

  // Expected strobes per state: {we, detect, ld, laf, lfd, full, rst_int, busy}.
  function automatic logic [7:0] exp_outs(input logic [3:0] st);
    case (st)
      4'd1:    return 8'b0100_0000;
      4'd2:    return 8'b0000_0001;
      4'd3:    return 8'b0000_1001;
      4'd4:    return 8'b1010_0000;
      4'd5:    return 8'b1000_0001;
      4'd6:    return 8'b0000_0101;
      4'd7:    return 8'b1001_0001;
      4'd8:    return 8'b0000_0011;
      default: return 8'b0000_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: shortly after each rising edge, compare against the oldest expectation.
  initial begin
    logic [3:0] e;
    forever begin
      @(posedge clock);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("state(exp %0d)", e), {4'b0, dut.present_state}, {4'b0, e});
        check($sformatf("outputs(state %0d)", e),
              {write_enb_reg, detect_add, ld_state, laf_state, lfd_state, full_state,
               rst_int_reg, busy}, exp_outs(e));
      end
    end
  end

  // Inputs are already applied (at a falling edge); record the state expected after the next rise.
  task automatic tick(input logic [3:0] exp);
    exp_q.push_back(exp);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'b00; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_packet_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b1;
    tick(4'd1);
    resetn = 1'b0;
  endtask

  // Header to FIFO 2 (empty), leaving the FSM in LOAD_DATA with pkt_valid high.
  task automatic header_to_2();
    pkt_valid = 1'b1; data_in = 2'b10; fifo_empty_2 = 1'b1;
    tick(4'd3);
    tick(4'd4);
  endtask

  initial begin
    idle_inputs();
    @(negedge clock);

    // Short packet: 1-3-4-5-8-1
    do_reset();
    header_to_2();
    pkt_valid = 1'b0;
    tick(4'd5);
    tick(4'd8);
    tick(4'd1);

    // Full stall, short tail: 1-3-4-6-7-5-8-1
    do_reset();
    header_to_2();
    fifo_full = 1'b1;
    tick(4'd6);
    fifo_full = 1'b0; pkt_valid = 1'b0; low_packet_valid = 1'b1;
    tick(4'd7);
    tick(4'd5);
    low_packet_valid = 1'b0;
    tick(4'd8);
    tick(4'd1);

    // Full stall, long packet: 1-3-4-6-7-4-5-8-1
    do_reset();
    header_to_2();
    fifo_full = 1'b1;
    tick(4'd6);
    fifo_full = 1'b0;
    tick(4'd7);
    tick(4'd4);
    pkt_valid = 1'b0;
    tick(4'd5);
    tick(4'd8);
    tick(4'd1);

    // Full at parity check: 1-3-4-5-8-6-7-1
    do_reset();
    header_to_2();
    pkt_valid = 1'b0;
    tick(4'd5);
    fifo_full = 1'b1;
    tick(4'd8);
    tick(4'd6);
    fifo_full = 1'b0;
    tick(4'd7);
    parity_done = 1'b1;
    tick(4'd1);
    parity_done = 1'b0;

    // Wait on busy FIFO 1, then soft reset back to decode
    do_reset();
    pkt_valid = 1'b1; data_in = 2'b01; fifo_empty_1 = 1'b0;
    tick(4'd2);
    tick(4'd2);
    soft_reset_1 = 1'b1;
    tick(4'd1);
    soft_reset_1 = 1'b0;

    // Wait, then FIFO 1 drains; soft reset of an unrelated FIFO is ignored
    tick(4'd2);
    fifo_empty_1 = 1'b1;
    tick(4'd3);
    tick(4'd4);
    soft_reset_0 = 1'b1;
    tick(4'd4);
    soft_reset_0 = 1'b0;

    // Reset from mid-packet returns to decode
    resetn = 1'b1;
    tick(4'd1);
    resetn = 1'b0;

    // Invalid address 2'b11 stays idle
    pkt_valid = 1'b1; data_in = 2'b11;
    tick(4'd1);
    tick(4'd1);
    pkt_valid = 1'b0; data_in = 2'b00;
    tick(4'd1);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_ctrl_fsm.md
Name: router_ctrl_fsm

Overview:
Control FSM of the 1x3 packet router. Decodes the 2-bit destination address in the header, waits for the target output FIFO to drain, and sequences header/payload/parity loading. Handles FIFO-full stalls and the parity check, and drives the load/write/busy strobes consumed by the router register and synchronizer blocks.

Parameters:
DECODE_ADDRESS, 4'b0001, state encoding (reset state)
WAIT_TILL_EMPTY, 4'b0010, state encoding
LOAD_FIRST_DATA, 4'b0011, state encoding
LOAD_DATA, 4'b0100, state encoding
LOAD_PARITY, 4'b0101, state encoding
FIFO_FULL_STATE, 4'b0110, state encoding
LOAD_AFTER_FULL, 4'b0111, state encoding
CHECK_PARITY_ERROR, 4'b1000, state encoding

Ports:
clock  in  1  system clock; all state updates on the rising edge
resetn  in  1  reset, synchronous, asserted high; forces DECODE_ADDRESS
pkt_valid  in  1  packet in progress (high from header through last payload byte)
data_in  in  2  destination address (header bits [1:0]); 2'b11 is invalid
fifo_full  in  1  full flag of the currently addressed FIFO
fifo_empty_0/1/2  in  1 each  empty flags of output FIFOs 0..2
soft_reset_0/1/2  in  1 each  per-FIFO read-timeout soft reset
parity_done  in  1  parity byte has been written
low_packet_valid  in  1  pkt_valid fell while in full stall
write_enb_reg  out  1  register/FIFO write enable
detect_add  out  1  in DECODE_ADDRESS
ld_state  out  1  in LOAD_DATA
laf_state  out  1  in LOAD_AFTER_FULL
lfd_state  out  1  in LOAD_FIRST_DATA
full_state  out  1  in FIFO_FULL_STATE
rst_int_reg  out  1  in CHECK_PARITY_ERROR
busy  out  1  router cannot accept new input byte

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- State register: 4-bit, named present_state. It is hierarchically visible for debug.
- Reset: present_state = DECODE_ADDRESS on the next rising edge. Reset has priority over every transition.
- Reset outputs: detect_add=1. All other outputs are 0.
- Address latch: an internal 2-bit register captures data_in whenever in DECODE_ADDRESS with pkt_valid=1.
- Soft reset: if soft_reset_N for the latched address is high (any non-reset state), next state = DECODE_ADDRESS. Soft reset has priority over the normal transitions.
- DECODE_ADDRESS transitions:
  - pkt_valid=1, data_in=N (N in 0..2), fifo_empty_N=1 -> LOAD_FIRST_DATA.
  - pkt_valid=1, data_in=N, fifo_empty_N=0 -> WAIT_TILL_EMPTY.
  - Otherwise, including data_in=2'b11 -> stay.
- WAIT_TILL_EMPTY: fifo_empty of the latched address =1 -> LOAD_FIRST_DATA; else stay.
- LOAD_FIRST_DATA: unconditional -> LOAD_DATA.
- LOAD_DATA transitions:
  - fifo_full=1 -> FIFO_FULL_STATE.
  - Else pkt_valid=0 -> LOAD_PARITY.
  - Else stay.
- FIFO_FULL_STATE: fifo_full=1 -> stay; else -> LOAD_AFTER_FULL.
- LOAD_AFTER_FULL transitions:
  - parity_done=1 -> DECODE_ADDRESS.
  - Else low_packet_valid=1 -> LOAD_PARITY.
  - Else -> LOAD_DATA.
- LOAD_PARITY: unconditional -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
- Undefined encodings -> DECODE_ADDRESS.
- Outputs are combinational decodes of present_state (Moore):
  - detect_add = DECODE_ADDRESS; lfd_state = LOAD_FIRST_DATA; ld_state = LOAD_DATA.
  - laf_state = LOAD_AFTER_FULL; full_state = FIFO_FULL_STATE; rst_int_reg = CHECK_PARITY_ERROR.
  - write_enb_reg = LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL.
  - busy = 1 in every state except DECODE_ADDRESS and LOAD_DATA.
- Latency: header accepted in cycle 0 (DECODE_ADDRESS). lfd_state is high in cycle 1 when the target FIFO is empty.
- Unknown inputs while idle in DECODE_ADDRESS must not leave the state. pkt_valid=X is treated as no transition.

Test Plan:
- Short packet. After resetn pulse: pkt_valid=1, data_in=2'b10, fifo_empty_2=1. Drop pkt_valid after 2 cycles, fifo_full=0.
  - Required state sequence 1-3-4-5-8-1.
  - busy=1 in states 3/5/8; write_enb_reg=1 in states 4/5; rst_int_reg=1 in state 8.
- Full stall, short tail. As above, but fifo_full=1 for one cycle in LOAD_DATA, then 0; parity_done=0, low_packet_valid=1.
  - Required sequence 1-3-4-6-7-5-8-1. full_state=1 in state 6, laf_state=1 in state 7.
- Full stall, long packet. fifo_full pulse in LOAD_DATA; low_packet_valid=0, parity_done=0; then pkt_valid=0.
  - Required sequence 1-3-4-6-7-4-5-8-1.
- Full at parity. Short packet with fifo_full=1 in CHECK_PARITY_ERROR, then 0, then parity_done=1.
  - Required sequence 1-3-4-5-8-6-7-1.
- Wait then soft reset. pkt_valid=1, data_in=2'b01, fifo_empty_1=0 -> state 2 with busy=1.
  - soft_reset_1=1 -> state 1 next cycle.
  - Alternatively fifo_empty_1=1 -> state 3.
- Reset and invalid address. resetn=1 in any state -> state 1 next edge with detect_add=1, busy=0. data_in=2'b11 with pkt_valid=1 -> stays in state 1.
